// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / static stream mux.
// Imported by the arbiter and the mux top.
package mux_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2_n(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2_n(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [SW:0]   sum;
    logic [SW-1:0] idx;

    // Scan farthest slot first so the slot nearest ptr wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SW + 1)'(k);
            if (sum >= (SW + 1)'(N)) begin
                sum = sum - (SW + 1)'(N);
            end
            idx = sum[SW-1:0];
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel W-bit stream mux with valid/ready per channel, static or
// round-robin selection, and a registered output stage.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 4,
    localparam int SW = clog2_n(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]       ch_data [N];
    logic [2**SW-1:0]   valid_ext;
    logic [SW-1:0]      ptr;
    logic [SW-1:0]      rr_idx;
    logic               rr_any;
    logic               st_ok;
    logic [SW-1:0]      grant;
    logic               grant_ok;
    logic               load;
    logic               xfer;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*W +: W];
    end

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Widened so an out-of-range sel never indexes past in_valid.
    assign valid_ext = (2**SW)'(in_valid);
    assign st_ok     = ({1'b0, sel} < (SW + 1)'(N)) && valid_ext[sel];

    always_comb begin
        grant    = sel;
        grant_ok = st_ok;
        if (mode == MODE_RR) begin
            grant    = rr_idx;
            grant_ok = rr_any;
        end
    end

    assign load = !out_valid || out_ready;
    assign xfer = !rst && load && grant_ok;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready = N'(1) << grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant];
            out_ch    <= grant;
            if (mode == MODE_RR) begin
                ptr <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
            end
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed scenarios plus a randomized run against a behavioural
// model of the stream mux.
module tb_mux_rr_n;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    int errors = 0;
    int checks = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    always #5 clk = ~clk;

    mux_rr_n #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic bit model_ok();
        if (mode == 1'b0) return (int'(sel) < N) && in_valid[sel];
        return |in_valid;
    endfunction

    function automatic int model_grant();
        int c;
        if (mode == 1'b0) return int'(sel);
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] model_ready();
        bit ld;
        ld = !m_valid || out_ready;
        if (rst || !ld || !model_ok()) return '0;
        return N'(1) << model_grant();
    endfunction

    task automatic tick();
        int           g;
        bit           ld;
        bit           x;
        logic [W-1:0] d;
        g  = model_grant();
        ld = !m_valid || out_ready;
        x  = !rst && ld && model_ok();
        d  = in_data[g*W +: W];
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (x) begin
            m_valid = 1;
            m_data  = d;
            m_ch    = g;
            if (mode == 1'b1) m_ptr = (g + 1) % N;
        end else if (ld) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst       = 1;
        in_valid  = '1;
        out_ready = 0;
        mode      = 0;
        sel       = 0;
        in_data   = 16'hECFA;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h ch=%0d exp v=0 d=0 ch=0",
                     out_valid, out_data, out_ch);
        end
        rst       = 0;
        out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_first got v=%b d=%h ch=%0d exp v=1 d=a ch=0",
                     out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_static_sweep();
        logic [W-1:0] seq [4];
        seq = '{4'hA, 4'hF, 4'hC, 4'hE};
        for (int i = 0; i < 4; i++) begin
            sel = SW'(i);
            tick();
            checks++;
            if (out_data !== seq[i] || out_ch !== SW'(i) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL static_sweep%0d got d=%h ch=%0d exp d=%h ch=%0d",
                         i, out_data, out_ch, seq[i], i);
            end
        end
    endtask

    task automatic test_idle_channel();
        sel      = 2;
        in_valid = 4'b1011;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ready got=%b exp=0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got=%b exp=0", out_valid);
        end
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL idle_wake_ready got=%b exp=0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 4'hC) begin
            errors++;
            $display("FAIL idle_wake got v=%b d=%h ch=%0d exp v=1 d=c ch=2",
                     out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_rr_fairness();
        mode     = 1;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_ch !== SW'(i % 4) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_all%0d got ch=%0d v=%b exp ch=%0d v=1",
                         i, out_ch, out_valid, i % 4);
            end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_ch !== ((i % 2 == 0) ? 2'd1 : 2'd3)) begin
                errors++;
                $display("FAIL rr_odd%0d got ch=%0d exp ch=%0d",
                         i, out_ch, (i % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid  = 4'b1111;
        out_ready = 1;
        tick();
        checks++;
        if (out_ch !== 2'd0 || out_data !== 4'hA) begin
            errors++;
            $display("FAIL bp_prime got ch=%0d d=%h exp ch=0 d=a", out_ch, out_data);
        end
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready%0d got=%b exp=0000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 4'hA) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h ch=%0d exp v=1 d=a ch=0",
                         i, out_valid, out_data, out_ch);
            end
        end
        in_data   = 16'hECFA;
        out_ready = 1;
        tick();
        checks++;
        if (out_ch !== 2'd1 || out_data !== 4'hF) begin
            errors++;
            $display("FAIL bp_resume got ch=%0d d=%h exp ch=1 d=f", out_ch, out_data);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        checks++;
        if (out_ch !== 2'd2) begin
            errors++;
            $display("FAIL mid_pre got ch=%0d exp ch=2", out_ch);
        end
        rst = 1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_ready got=%b exp=0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_valid got=%b exp=0", out_valid);
        end
        rst = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 4'hA) begin
            errors++;
            $display("FAIL mid_first got v=%b ch=%0d d=%h exp v=1 ch=0 d=a",
                     out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = SW'($urandom);
            in_data   = 16'($urandom);
            #1;
            er = model_ready();
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL rnd_ready%0d got=%b exp=%b", i, in_ready, er);
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== SW'(m_ch)) begin
                errors++;
                $display("FAIL rnd_out%0d got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                         i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
    endtask

    initial begin
        m_valid = 0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
        test_reset();
        test_static_sweep();
        test_idle_channel();
        test_rr_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a per-channel valid/ready handshake and a registered output stage.
- Two modes:
  - Static: software-style select through `sel`.
  - Round-robin: fair arbitration among valid channels.
- Sits between several producer streams and one consumer, replacing the fixed combinational 4:1 mux where flow control and fairness are needed.

Parameters:
- N, 4, number of input channels (2..16).
- W, 4, data width per channel in bits (1..64).
- SW, $clog2(N), width of the select and channel-index fields. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit is high per cycle.
- mode  input  1  0 = static select, 1 = round-robin.
- sel  input  SW  channel to pass in static mode; ignored in round-robin mode.
- out_data  output  W  registered selected data.
- out_ch  output  SW  index of the channel that produced out_data.
- out_valid  output  1  output holds a valid word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset, synchronous on the clk edge with rst=1:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 during the reset cycle.
- Load condition:
  - load = !out_valid || out_ready.
  - in_ready is combinational from load, mode, sel, in_valid and ptr.
- Grant in static mode:
  - grant_ok = (sel < N) && in_valid[sel]; grant = sel.
  - sel >= N (non-power-of-2 N) gives no grant, and in_ready stays all-zero.
- Grant in round-robin mode:
  - grant is the first i with in_valid[i] set, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - grant_ok = |in_valid.
- Transfer:
  - in_ready[grant] = load && grant_ok; all other in_ready bits are 0.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Output register, on a transfer:
  - out_data <= in_data[grant]; out_ch <= grant; out_valid <= 1.
  - In round-robin mode, ptr <= (grant+1) mod N, wrapping N-1 -> 0.
  - In static mode, ptr is unchanged.
- Output register, no transfer:
  - load && !grant_ok: out_valid <= 0; out_data and out_ch hold.
  - !load (stall): out_data, out_ch and out_valid all hold.
- Throughput and latency:
  - One word per cycle when out_ready is held high.
  - Latency is 1 cycle from input transfer to out_valid.
- Simultaneous events:
  - A consumer pop and a new load in the same cycle give back-to-back valid words with no bubble.
  - With rst=1, reset wins over any transfer and in_ready is 0.
- Mode and select changes:
  - A mode or sel change is sampled combinationally and applies on the next grant.
  - A word already in the output register is unaffected.
  - ptr is preserved across mode changes.
- Stability rule: while out_valid && !out_ready, out_data and out_ch must not change.
- Reset mid-operation: a pending output word is discarded and out_valid=0 on the following cycle.

Decomposition:
- Package mux_pkg:
  - Mode constants MODE_STATIC=1'b0 and MODE_RR=1'b1.
  - A function returning the clog2 of N.
- Sub-module rr_arbiter (N), purely combinational:
  - Inputs: req[N], ptr[SW].
  - Outputs: gnt_idx[SW], gnt_any.
  - Used for round-robin mode only. The pointer register lives in mux_rr_n.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with all in_valid=1.
  - Required: out_valid=0, out_data=0, in_ready=0.
  - Then rst=0, mode=0, sel=0, in_data ch0=4'hA: the next cycle gives out_data=4'hA, out_ch=0.
- Static select sweep:
  - Stimulus: N=4, W=4, in_data ch0..3 = A,F,C,E; all valid; out_ready=1; sel stepped 0,1,2,3 one per cycle.
  - Required: out_data sequence A,F,C,E with out_ch 0,1,2,3, each one cycle after its sel.
- Static select on an idle channel:
  - Stimulus: sel=2, in_valid=4'b1011.
  - Required: in_ready=0000 and out_valid drops to 0. Setting in_valid[2]=1 then gives a transfer on the next edge.
- Round-robin fairness:
  - Stimulus: mode=1, all in_valid=1, out_ready=1 for 8 cycles.
  - Required: out_ch=0,1,2,3,0,1,2,3.
  - With in_valid=4'b1010: out_ch alternates 1,3,1,3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1.
  - Required: in_ready=0000, out_data and out_ch stable, ptr frozen.
  - Releasing out_ready resumes from the next channel in order.
- Reset mid-stream:
  - Stimulus: rst=1 during round-robin traffic with out_ch=2.
  - Required: out_valid=0 and ptr=0. After release the first grant is channel 0.
